aes_block_arbiter: RTL and testbench
====================================

# aes_block_arbiter

Round-robin scheduler sharing one 32→128-bit byte stacker / AES core / 128→32-bit byte unstacker pipeline between N_REQ 32-bit requester streams. Grants the shared ingress to one requester for exactly one 128-bit block (4 words). Records the owner in a tag FIFO and steers the 4 returned words back to that requester. Sits between the HWPE streamer ports and the stacker input / unstacker output.

## Interface
- N_REQ, 2: number of requesters, 2..8; index width IW = max(1, clog2(N_REQ)).
- TAG_DEPTH, 4: tag FIFO depth (blocks in flight), power of two, ≥2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- clr_i  in  1  synchronous clear, same effect as reset.
- enable_i  in  1  when 0: all valid/ready outputs forced 0, all state held.
- req_valid_i  in  N_REQ  per-requester word valid.
- req_word_i  in  32*N_REQ  requester r word at [32r+31:32r].
- req_ready_o  out  N_REQ  per-requester ready.
- stk_valid_o  out  1  word valid to stacker.
- stk_word_o  out  32  word to stacker.
- stk_ready_i  in  1  stacker ready.
- ret_valid_i  in  1  word valid from unstacker.
- ret_word_i  in  32  word from unstacker.
- ret_ready_o  out  1  ready to unstacker.
- rsp_valid_o  out  N_REQ  per-requester response valid.
- rsp_word_o  out  32*N_REQ  response word, ret_word_i broadcast to all slices.
- rsp_ready_i  in  N_REQ  per-requester response ready.
- busy_o  out  1  ingress LOCKED or tag FIFO non-empty.
- err_o  out  1  sticky: return beat presented while tag FIFO empty.

## Operation
- Ingress FSM, states IDLE, LOCKED; registers grant (IW), ptr (IW), in_cnt (2b).
- IDLE: if any req_valid_i and tag FIFO not full: grant ← first valid index scanning ptr, ptr+1, … modulo N_REQ; push grant into tag FIFO; in_cnt ← 0; → LOCKED. No words pass in IDLE (all req_ready_o = 0, stk_valid_o = 0).
- LOCKED: stk_valid_o = req_valid_i[grant]; stk_word_o = req_word_i slice grant; req_ready_o[grant] = stk_ready_i, others 0. Each handshake increments in_cnt. Handshake with in_cnt = 3 → IDLE, ptr ← grant+1 mod N_REQ.
- Requester deasserting valid mid-block: FSM stays LOCKED, waits; no re-arbitration until 4 beats complete.
- Tag FIFO: push only from IDLE grant (never when full); pop on 4th egress handshake; simultaneous push+pop allowed at any occupancy, occupancy unchanged.
- Egress: head tag h valid when FIFO non-empty. rsp_valid_o[h] = ret_valid_i, others 0; ret_ready_o = rsp_ready_i[h]. out_cnt (2b) increments per ret handshake; handshake with out_cnt = 3 pops FIFO and out_cnt ← 0.
- FIFO empty: ret_ready_o = 0, rsp_valid_o = 0; if ret_valid_i = 1 also, err_o ← 1 (cleared only by reset/clr_i).
- Ingress and egress independent; same requester may hold ingress while receiving responses.
- clr_i (when enable_i=1 or 0): state → IDLE, ptr, counters, FIFO pointers, err_o → 0; in-flight blocks discarded (caller also clears stacker/unstacker).

## Timing
- Reset/clr values: req_ready_o = 0, stk_valid_o = 0, ret_ready_o = 0, rsp_valid_o = 0, busy_o = 0, err_o = 0, ptr = 0, state IDLE.
- Arbitration: 1 cycle (IDLE) per block; first word accepted earliest cycle after grant. Peak ingress: 4 words / 5 cycles.
- Per-word paths combinational: stk_* from req_* and stk_ready_i, rsp_* / ret_ready_o from ret_valid_i and rsp_ready_i; zero added latency.
- busy_o, err_o registered.

## Test plan
- Single requester 0 sends AAAAAAAA, BBBBBBBB, 12345678, 55555555; loopback model returns them -> rsp_valid_o[0] only, same 4 words in order, busy_o drops 1 cycle after last return.
- Both requesters valid from cycle 0, 2 blocks each -> ingress order r0, r1, r0, r1; each requester receives only its own words.
- r1 valid, r0 idle, ptr = 0 -> r1 granted; next block with both valid -> r0 granted (ptr = 0 after r1).
- TAG_DEPTH=2, unstacker holding ret_valid_i = 0 -> third block not granted (stays IDLE, req_ready_o = 0) until first block's 4th return beat pops.
- Head tag r0 with rsp_ready_i[0] = 0, rsp_ready_i[1] = 1 -> ret_ready_o = 0, no progress; release -> 4 words to r0.
- ret_valid_i = 1 with empty FIFO -> err_o = 1 next cycle, ret_ready_o = 0; clr_i pulse mid-block -> err_o = 0, busy_o = 0, state IDLE.

Source files
------------

// File: rtl/aes_block_arbiter.sv
// aes_block_arbiter
//   Round-robin scheduler sharing one stacker / AES core / unstacker pipeline
//   between N_REQ 32-bit requester streams. The ingress is granted to one
//   requester for exactly one 128-bit block (4 words). The owner of each
//   block is queued in a tag FIFO so the 4 returned words can be steered
//   back to the requester that issued them.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clr_i                synchronous clear, same effect as reset
//   enable_i             0: all valid/ready outputs forced low, state held
//   req_valid_i/word_i   per-requester ingress stream (word r at [32r+31:32r])
//   req_ready_o          per-requester ingress ready
//   stk_valid_o/word_o   word stream towards the stacker
//   stk_ready_i          stacker ready
//   ret_valid_i/word_i   word stream from the unstacker
//   ret_ready_o          ready towards the unstacker
//   rsp_valid_o          per-requester response valid
//   rsp_word_o           ret_word_i broadcast to every requester slice
//   rsp_ready_i          per-requester response ready
//   busy_o               ingress locked or blocks in flight (registered)
//   err_o                sticky: return beat seen with no block in flight
module aes_block_arbiter #(
    parameter int N_REQ     = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  enable_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    input  logic [32*N_REQ-1:0]   req_word_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic                  stk_valid_o,
    output logic [31:0]           stk_word_o,
    input  logic                  stk_ready_i,
    input  logic                  ret_valid_i,
    input  logic [31:0]           ret_word_i,
    output logic                  ret_ready_o,
    output logic [N_REQ-1:0]      rsp_valid_o,
    output logic [32*N_REQ-1:0]   rsp_word_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        S_IDLE,
        S_LOCKED
    } state_t;

    // Index base+off wrapped into 0..N_REQ-1 (N_REQ need not be a power of two).
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [1:0]      in_cnt_q, in_cnt_d;
    logic [1:0]      out_cnt_q, out_cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [IW-1:0]   tags [TAG_DEPTH];

    logic            fifo_full, fifo_empty;
    logic [IW-1:0]   head;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            push, pop;
    logic            in_hs, out_hs;

    assign fifo_full  = (count_q == CW'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tags[rd_ptr_q];

    // Round-robin pick: first valid requester starting at ptr_q.
    // NOTE: every variable written in an always_comb gets a default at the top,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = wrap_idx(ptr_q, i);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign push   = enable_i && (state_q == S_IDLE) && pick_found && !fifo_full;
    assign in_hs  = enable_i && (state_q == S_LOCKED) && req_valid_i[grant_q] && stk_ready_i;
    assign out_hs = enable_i && !fifo_empty && ret_valid_i && rsp_ready_i[head];
    assign pop    = out_hs && (out_cnt_q == 2'd3);

    // Ingress datapath: purely combinational, no added latency.
    always_comb begin
        req_ready_o = '0;
        stk_valid_o = 1'b0;
        stk_word_o  = req_word_i[32*grant_q +: 32];
        if (enable_i && state_q == S_LOCKED) begin
            req_ready_o[grant_q] = stk_ready_i;
            stk_valid_o          = req_valid_i[grant_q];
        end
    end

    // Egress datapath: the head tag selects the receiving requester.
    always_comb begin
        rsp_valid_o = '0;
        ret_ready_o = 1'b0;
        if (enable_i && !fifo_empty) begin
            rsp_valid_o[head] = ret_valid_i;
            ret_ready_o       = rsp_ready_i[head];
        end
    end

    assign rsp_word_o = {N_REQ{ret_word_i}};

    // Ingress FSM next state.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        in_cnt_d = in_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (push) begin
                    grant_d  = pick_idx;
                    in_cnt_d = 2'd0;
                    state_d  = S_LOCKED;
                end
            end
            S_LOCKED: begin
                // A stalled requester keeps the lock until all 4 beats pass.
                if (in_hs) begin
                    in_cnt_d = in_cnt_q + 2'd1;
                    if (in_cnt_q == 2'd3) begin
                        state_d = S_IDLE;
                        ptr_d   = wrap_idx(grant_q, 1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tag FIFO bookkeeping, egress beat counter and status flags.
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        out_cnt_d = out_hs ? out_cnt_q + 2'd1 : out_cnt_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        busy_d = (state_d == S_LOCKED) || (count_d != '0);
        err_d  = err_q || (enable_i && fifo_empty && ret_valid_i);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (clr_i) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the tag storage has no reset; entries are only read after being
    // written, and the FIFO pointers/count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push && !clr_i) begin
            tags[wr_ptr_q] <= pick_idx;
        end
    end

    assign busy_o = busy_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_aes_block_arbiter.sv
// Directed bench for aes_block_arbiter with N_REQ=2, TAG_DEPTH=2.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_aes_block_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clr_i;
    logic         enable_i;
    logic [1:0]   req_valid_i;
    logic [63:0]  req_word_i;
    logic [1:0]   req_ready_o;
    logic         stk_valid_o;
    logic [31:0]  stk_word_o;
    logic         stk_ready_i;
    logic         ret_valid_i;
    logic [31:0]  ret_word_i;
    logic         ret_ready_o;
    logic [1:0]   rsp_valid_o;
    logic [63:0]  rsp_word_o;
    logic [1:0]   rsp_ready_i;
    logic         busy_o;
    logic         err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] src0[$];
    logic [31:0] src1[$];
    logic [31:0] stk_log[$];
    int          owner_log[$];

    aes_block_arbiter #(.N_REQ(2), .TAG_DEPTH(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .enable_i    (enable_i),
        .req_valid_i (req_valid_i),
        .req_word_i  (req_word_i),
        .req_ready_o (req_ready_o),
        .stk_valid_o (stk_valid_o),
        .stk_word_o  (stk_word_o),
        .stk_ready_i (stk_ready_i),
        .ret_valid_i (ret_valid_i),
        .ret_word_i  (ret_word_i),
        .ret_ready_o (ret_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_word_o  (rsp_word_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Acts as stacker: accepts words from the queued requester streams until
    // n_words handshakes have been seen, logging word and owner of each.
    task automatic pump(input int n_words, input string tag);
        int got = 0;
        int budget = 0;
        while (got < n_words && budget < 100) begin
            req_valid_i[0]    = (src0.size() > 0);
            req_valid_i[1]    = (src1.size() > 0);
            req_word_i[31:0]  = (src0.size() > 0) ? src0[0] : 32'h0;
            req_word_i[63:32] = (src1.size() > 0) ? src1[0] : 32'h0;
            #1;
            if (stk_valid_o && stk_ready_i) begin
                stk_log.push_back(stk_word_o);
                if (req_ready_o[0] && req_valid_i[0]) begin
                    owner_log.push_back(0);
                    void'(src0.pop_front());
                end else if (req_ready_o[1] && req_valid_i[1]) begin
                    owner_log.push_back(1);
                    void'(src1.pop_front());
                end else begin
                    owner_log.push_back(-1);
                end
                got++;
            end
            @(negedge clk_i);
            budget++;
        end
        req_valid_i = '0;
        check({tag, "_ingress_words"}, 64'(got), 64'(n_words));
    endtask

    // Acts as unstacker: returns 4 words and checks they are steered to owner.
    task automatic ret_block(input int owner, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input string tag);
        logic [31:0] w [4];
        int i = 0;
        int budget = 0;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        rsp_ready_i = 2'b11;
        while (i < 4 && budget < 50) begin
            ret_valid_i = 1'b1;
            ret_word_i  = w[i];
            #1;
            check($sformatf("%s_rspv%0d", tag, i), 64'(rsp_valid_o), (owner == 0) ? 64'h1 : 64'h2);
            check($sformatf("%s_rspw%0d", tag, i), 64'(rsp_word_o[32*owner +: 32]), 64'(w[i]));
            if (ret_ready_o) i++;
            @(negedge clk_i);
            budget++;
        end
        ret_valid_i = 1'b0;
        check({tag, "_return_beats"}, 64'(i), 64'd4);
    endtask

    task automatic clear_pulse;
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        src0.delete();
        src1.delete();
        stk_log.delete();
        owner_log.delete();
    endtask

    initial begin
        rst_ni      = 1'b0;
        clr_i       = 1'b0;
        enable_i    = 1'b1;
        req_valid_i = '0;
        req_word_i  = '0;
        stk_ready_i = 1'b1;
        ret_valid_i = 1'b0;
        ret_word_i  = '0;
        rsp_ready_i = 2'b11;

        // Reset state.
        #2;
        check("rst_req_ready", 64'(req_ready_o), 64'h0);
        check("rst_stk_valid", 64'(stk_valid_o), 64'h0);
        check("rst_ret_ready", 64'(ret_ready_o), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
        check("rst_busy",      64'(busy_o),      64'h0);
        check("rst_err",       64'(err_o),       64'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single requester, loopback of one block.
        req_valid_i      = 2'b01;
        req_word_i[31:0] = 32'hAAAAAAAA;
        #1;
        check("t1_idle_ready", 64'(req_ready_o), 64'h0);
        check("t1_idle_stkv",  64'(stk_valid_o), 64'h0);
        @(negedge clk_i);
        check("t1_busy_locked", 64'(busy_o), 64'h1);
        src0 = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'h12345678, 32'h55555555};
        pump(4, "t1");
        check("t1_w0", 64'(stk_log[0]), 64'hAAAAAAAA);
        check("t1_w1", 64'(stk_log[1]), 64'hBBBBBBBB);
        check("t1_w2", 64'(stk_log[2]), 64'h12345678);
        check("t1_w3", 64'(stk_log[3]), 64'h55555555);
        check("t1_owner", 64'(owner_log[3]), 64'h0);
        #1;
        check("t1_busy_inflight", 64'(busy_o), 64'h1);
        @(negedge clk_i);
        ret_block(0, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h12345678, 32'h55555555, "t1");
        #1;
        check("t1_busy_drop", 64'(busy_o), 64'h0);
        @(negedge clk_i);

        // Both requesters, two blocks each, TAG_DEPTH=2 backpressure.
        clear_pulse();
        for (int k = 0; k < 8; k++) begin
            src0.push_back(32'h10000000 + 32'(k));
            src1.push_back(32'h20000000 + 32'(k));
        end
        pump(8, "t2a");
        check("t2_owner_b0", 64'(owner_log[0]), 64'h0);
        check("t2_owner_b1", 64'(owner_log[4]), 64'h1);
        check("t2_word_b1",  64'(stk_log[4]),   64'h20000000);
        for (int k = 0; k < 3; k++) begin
            req_valid_i       = 2'b11;
            req_word_i[31:0]  = src0[0];
            req_word_i[63:32] = src1[0];
            #1;
            check($sformatf("t2_full_ready%0d", k), 64'(req_ready_o), 64'h0);
            check($sformatf("t2_full_stkv%0d", k),  64'(stk_valid_o), 64'h0);
            check($sformatf("t2_full_busy%0d", k),  64'(busy_o),      64'h1);
            @(negedge clk_i);
        end
        req_valid_i = '0;
        ret_block(0, 32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003, "t2r0a");
        pump(4, "t2b");
        check("t2_owner_b2", 64'(owner_log[8]), 64'h0);
        check("t2_word_b2",  64'(stk_log[8]),   64'h10000004);
        ret_block(1, 32'h20000000, 32'h20000001, 32'h20000002, 32'h20000003, "t2r1a");
        pump(4, "t2c");
        check("t2_owner_b3", 64'(owner_log[12]), 64'h1);
        check("t2_word_b3",  64'(stk_log[15]),   64'h20000007);
        ret_block(0, 32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007, "t2r0b");
        ret_block(1, 32'h20000004, 32'h20000005, 32'h20000006, 32'h20000007, "t2r1b");
        #1;
        check("t2_busy_end", 64'(busy_o), 64'h0);
        @(negedge clk_i);

        // r1 alone with ptr=0, then both valid: r0 wins next.
        clear_pulse();
        src1 = '{32'h30000000, 32'h30000001, 32'h30000002, 32'h30000003};
        pump(4, "t3a");
        check("t3_owner_r1", 64'(owner_log[0]), 64'h1);
        src0 = '{32'h40000000, 32'h40000001, 32'h40000002, 32'h40000003};
        src1 = '{32'h50000000, 32'h50000001, 32'h50000002, 32'h50000003};
        pump(4, "t3b");
        check("t3_owner_r0", 64'(owner_log[4]), 64'h0);
        check("t3_word_r0",  64'(stk_log[4]),   64'h40000000);
        src1.delete();
        ret_block(1, 32'h30000000, 32'h30000001, 32'h30000002, 32'h30000003, "t3r1");
        ret_block(0, 32'h40000000, 32'h40000001, 32'h40000002, 32'h40000003, "t3r0");

        // Head owner not ready while the other requester is.
        clear_pulse();
        src0 = '{32'h60000000, 32'h60000001, 32'h60000002, 32'h60000003};
        pump(4, "t5");
        for (int k = 0; k < 3; k++) begin
            rsp_ready_i = 2'b10;
            ret_valid_i = 1'b1;
            ret_word_i  = 32'h60000000;
            #1;
            check($sformatf("t5_hold_retr%0d", k), 64'(ret_ready_o), 64'h0);
            check($sformatf("t5_hold_rspv%0d", k), 64'(rsp_valid_o), 64'h1);
            @(negedge clk_i);
        end
        ret_block(0, 32'h60000000, 32'h60000001, 32'h60000002, 32'h60000003, "t5");
        #1;
        check("t5_busy_end", 64'(busy_o), 64'h0);
        @(negedge clk_i);

        // Return beat with empty FIFO sets sticky err_o.
        ret_valid_i = 1'b1;
        ret_word_i  = 32'hDEADBEEF;
        rsp_ready_i = 2'b11;
        #1;
        check("t6_empty_retr", 64'(ret_ready_o), 64'h0);
        check("t6_empty_rspv", 64'(rsp_valid_o), 64'h0);
        check("t6_err_before", 64'(err_o),       64'h0);
        @(negedge clk_i);
        ret_valid_i = 1'b0;
        #1;
        check("t6_err_set", 64'(err_o), 64'h1);
        @(negedge clk_i);
        check("t6_err_sticky", 64'(err_o), 64'h1);

        // Partial block, enable low holds state, then clr mid-block.
        src0 = '{32'h70000000, 32'h70000001, 32'h70000002, 32'h70000003};
        pump(2, "t6");
        req_valid_i      = 2'b01;
        req_word_i[31:0] = src0[0];
        enable_i         = 1'b0;
        #1;
        check("t6_dis_ready", 64'(req_ready_o), 64'h0);
        check("t6_dis_stkv",  64'(stk_valid_o), 64'h0);
        check("t6_dis_busy",  64'(busy_o),      64'h1);
        @(negedge clk_i);
        enable_i = 1'b1;
        #1;
        check("t6_held_locked", 64'(req_ready_o), 64'h1);
        check("t6_held_word",   64'(stk_word_o),  64'h70000002);
        @(negedge clk_i);
        req_valid_i = '0;
        clear_pulse();
        req_valid_i      = 2'b01;
        req_word_i[31:0] = 32'h70000003;
        #1;
        check("t6_clr_err",   64'(err_o),       64'h0);
        check("t6_clr_busy",  64'(busy_o),      64'h0);
        check("t6_clr_ready", 64'(req_ready_o), 64'h0);
        check("t6_clr_stkv",  64'(stk_valid_o), 64'h0);
        check("t6_clr_retr",  64'(ret_ready_o), 64'h0);
        req_valid_i = '0;
        @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
